// File: rtl/neuron_mac.sv
// neuron_mac: fixed-point multiply-accumulate for one neuron. It seeds the
// accumulator with bias, adds LEN products x_in*w_in, then rescales and
// saturates the sum into phase_out.
// Ports: clk, rst (async, active high), start/bias (begin a dot product),
//   in_valid/in_ready with x_in/w_in (operand pairs),
//   out_valid/out_ready with phase_out (result), busy (not idle).
module neuron_mac #(
  parameter int N   = 32,
  parameter int Q   = 16,
  parameter int LEN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] bias,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] w_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] phase_out,
  output logic         busy
);

  // Headroom of clog2(LEN)+1 bits means LEN full-scale products plus the
  // shifted bias cannot wrap.
  localparam int AW = 2*N + $clog2(LEN) + 1;
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FIN,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] phase_q, phase_d;
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic busy_q, busy_d;

  logic signed [2*N-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] bias_ext;
  logic signed [AW-1:0] shifted;
  logic [AW-N:0] hi;
  logic [N-1:0] sat;
  logic take;

  assign prod     = $signed(x_in) * $signed(w_in);
  assign prod_ext = $signed({{(AW-2*N){prod[2*N-1]}}, prod});
  assign bias_ext = $signed({{(AW-N){bias[N-1]}}, bias}) <<< Q;
  assign take     = in_valid & in_ready_q;

  // Arithmetic shift floors toward minus infinity. The value fits in N bits
  // only when every bit from N-1 upward is a copy of the sign.
  assign shifted = acc_q >>> Q;
  assign hi      = shifted[AW-1:N-1];

  always_comb begin
    sat = shifted[N-1:0];
    if (!(&hi) && (|hi)) begin
      if (shifted[AW-1]) begin
        sat = {1'b1, {(N-1){1'b0}}};
      end else begin
        sat = {1'b0, {(N-1){1'b1}}};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d      = bias_ext;
          cnt_d      = '0;
          state_d    = ACCUM;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ACCUM: begin
        if (take) begin
          acc_d = acc_q + prod_ext;
          if (cnt_q == LAST) begin
            state_d    = FIN;
            in_ready_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIN: begin
        phase_d     = sat;
        state_d     = OUT;
        out_valid_d = 1'b1;
      end
      OUT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      phase_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign phase_out = phase_q;
  assign busy      = busy_q;

endmodule
